sid_voice_osc: RTL and testbench

Oscillator stage of one SID voice: 24-bit phase accumulator with hard sync, ring modulation, test bit, 23-bit noise LFSR and pulse-width comparator. It produces the selected single/AND-combined 12-bit waveform and the 12-bit triangle index `tri_out`. `tri_out` drives the `wave` input of the combined-waveform ROM tables (pulse+triangle etc.) directly downstream. Three instances per SID, chained for sync and ring.

---
 rtl/sid_voice_osc.sv | 107 ++++++++++
 tb/tb_sid_voice_osc.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sid_voice_osc.sv
// Oscillator stage of one SID voice: 24-bit phase accumulator with hard sync,
// ring modulation, test bit, 23-bit noise LFSR and pulse-width comparator.
module sid_voice_osc #(
  parameter logic [22:0] NOISE_SEED = 23'h7FFFF8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce_1m,
  input  logic [15:0] freq,
  input  logic [11:0] pw,
  input  logic [7:0]  control,
  input  logic        sync_in,
  input  logic        ring_msb_in,
  output logic        acc_msb,
  output logic        msb_rise,
  output logic [11:0] tri_out,
  output logic [11:0] wave_out,
  output logic [7:0]  osc_out
);

  logic [23:0] acc_q, acc_d;
  logic [22:0] lfsr_q, lfsr_d;
  logic        msb_rise_q, msb_rise_d;
  logic [11:0] tri_q, tri_d;
  logic [11:0] wave_q, wave_d;

  logic        ctl_sync, ctl_ring, ctl_test;
  logic [3:0]  wave_sel;
  logic [23:0] acc_sum;
  logic        tri_msb;
  logic [11:0] saw_w, pulse_w, noise_w;
  logic        gate_unused;

  always_comb begin
    ctl_sync    = control[1];
    ctl_ring    = control[2];
    ctl_test    = control[3];
    wave_sel    = control[7:4];
    gate_unused = control[0];
  end

  // Phase accumulator, sync/test zeroing and noise clocking on SID cycles.
  always_comb begin
    acc_sum    = acc_q + {8'h00, freq};
    acc_d      = acc_q;
    lfsr_d     = lfsr_q;
    msb_rise_d = msb_rise_q;
    if (ce_1m) begin
      if (ctl_test) begin
        acc_d      = '0;
        msb_rise_d = 1'b0;
        lfsr_d     = NOISE_SEED;
      end else if (ctl_sync && sync_in) begin
        acc_d      = '0;
        msb_rise_d = 1'b0;
      end else begin
        acc_d      = acc_sum;
        msb_rise_d = ~acc_q[23] & acc_sum[23];
        if (~acc_q[19] && acc_sum[19]) begin
          lfsr_d = {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};
        end
      end
    end
  end

  // Waveform generators work from the pre-update state; several selected
  // waveforms are ANDed, accurate mixes come from the downstream ROMs.
  always_comb begin
    tri_msb = ctl_ring ? (acc_q[23] ^ ring_msb_in) : acc_q[23];
    tri_d   = {(tri_msb ? ~acc_q[22:12] : acc_q[22:12]), 1'b0};
    saw_w   = acc_q[23:12];
    pulse_w = (ctl_test || (acc_q[23:12] >= pw)) ? 12'hFFF : 12'h000;
    noise_w = {lfsr_q[22], lfsr_q[20], lfsr_q[16], lfsr_q[13],
               lfsr_q[11], lfsr_q[7],  lfsr_q[4],  lfsr_q[2], 4'h0};
    wave_d  = '1;
    if (wave_sel[0]) wave_d = wave_d & tri_d;
    if (wave_sel[1]) wave_d = wave_d & saw_w;
    if (wave_sel[2]) wave_d = wave_d & pulse_w;
    if (wave_sel[3]) wave_d = wave_d & noise_w;
    if (wave_sel == 4'h0) wave_d = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q      <= '0;
      lfsr_q     <= NOISE_SEED;
      msb_rise_q <= 1'b0;
      tri_q      <= '0;
      wave_q     <= '0;
    end else begin
      acc_q      <= acc_d;
      lfsr_q     <= lfsr_d;
      msb_rise_q <= msb_rise_d;
      tri_q      <= tri_d;
      wave_q     <= wave_d;
    end
  end

  always_comb begin
    acc_msb  = acc_q[23];
    msb_rise = msb_rise_q;
    tri_out  = tri_q;
    wave_out = wave_q;
    osc_out  = wave_q[11:4];
  end

endmodule

// File: tb/tb_sid_voice_osc.sv
// Scoreboard bench for sid_voice_osc: a behavioural voice model queues the
// expected outputs for each clock, each scenario task pops and compares them.
module tb_sid_voice_osc;

  localparam logic [22:0] SEED = 23'h7FFFF8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ce_1m = 1'b0;
  logic [15:0] freq = '0;
  logic [11:0] pw = '0;
  logic [7:0]  control = '0;
  logic        sync_in = 1'b0;
  logic        ring_msb_in = 1'b0;
  logic        acc_msb, msb_rise;
  logic [11:0] tri_out, wave_out;
  logic [7:0]  osc_out;

  typedef struct {
    logic [11:0] wave;
    logic [11:0] tri_v;
    logic        msb;
    logic        rise;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [23:0] m_acc = '0;
  logic [22:0] m_lfsr = SEED;
  logic        m_rise = 1'b0;
  int          checks = 0;
  int          failures = 0;

  sid_voice_osc #(.NOISE_SEED(SEED)) dut (
    .clock(clock), .reset(reset), .ce_1m(ce_1m), .freq(freq), .pw(pw),
    .control(control), .sync_in(sync_in), .ring_msb_in(ring_msb_in),
    .acc_msb(acc_msb), .msb_rise(msb_rise), .tri_out(tri_out),
    .wave_out(wave_out), .osc_out(osc_out)
  );

  always #5 clock = ~clock;

  function automatic logic [11:0] noise_of(input logic [22:0] l);
    return {l[22], l[20], l[16], l[13], l[11], l[7], l[4], l[2], 4'h0};
  endfunction

  // Advance the model one clock with the currently driven inputs, queue the
  // expected post-edge outputs, then step the DUT past the edge.
  task automatic tick(input logic ce);
    exp_t        x;
    logic [11:0] saw, tv, pul, w;
    logic        t;
    logic [23:0] sum;
    ce_1m = ce;
    saw = m_acc[23:12];
    t   = control[2] ? (m_acc[23] ^ ring_msb_in) : m_acc[23];
    tv  = t ? {~saw[10:0], 1'b0} : {saw[10:0], 1'b0};
    pul = (control[3] || saw >= pw) ? 12'hFFF : 12'h000;
    w   = (control[7:4] == 4'h0) ? 12'h000 : 12'hFFF;
    if (control[4]) w = w & tv;
    if (control[5]) w = w & saw;
    if (control[6]) w = w & pul;
    if (control[7]) w = w & noise_of(m_lfsr);
    if (reset) begin
      m_acc = '0; m_lfsr = SEED; m_rise = 1'b0; tv = '0; w = '0;
    end else if (ce) begin
      if (control[3]) begin
        m_acc = '0; m_rise = 1'b0; m_lfsr = SEED;
      end else if (control[1] && sync_in) begin
        m_acc = '0; m_rise = 1'b0;
      end else begin
        sum = m_acc + {8'h00, freq};
        if (!m_acc[19] && sum[19]) m_lfsr = {m_lfsr[21:0], m_lfsr[22] ^ m_lfsr[17]};
        m_rise = !m_acc[23] && sum[23];
        m_acc  = sum;
      end
    end
    x.wave = w; x.tri_v = tv; x.msb = m_acc[23]; x.rise = m_rise;
    sb.push_back(x);
    @(posedge clock);
    #1;
    ce_1m = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    void'(sb.pop_front());
  endtask

  task automatic test_reset();
    freq = 16'h1234; control = 8'hF0;
    tick(1'b1);
    tick(1'b1);
    sb.delete();
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({wave_out, tri_out, osc_out, acc_msb, msb_rise} !== 34'h0) begin
      failures++;
      $display("FAIL reset_outputs wave=%h tri=%h osc=%h msb=%b rise=%b, required all 0",
               wave_out, tri_out, osc_out, acc_msb, msb_rise);
    end
    checks++;
    if ({wave_out, tri_out, acc_msb, msb_rise} !== {e.wave, e.tri_v, e.msb, e.rise}) begin
      failures++;
      $display("FAIL reset_model wave=%h tri=%h required wave=%h tri=%h", wave_out, tri_out, e.wave, e.tri_v);
    end
  endtask

  task automatic test_saw();
    do_reset();
    freq = 16'h8000; control = 8'h20;
    for (int i = 0; i < 256; i++) begin
      tick(1'b1);
      e = sb.pop_front();
      checks++;
      if ({wave_out, tri_out, acc_msb, msb_rise} !== {e.wave, e.tri_v, e.msb, e.rise}) begin
        failures++;
        $display("FAIL saw_step%0d wave=%h tri=%h msb=%b rise=%b required %h %h %b %b", i,
                 wave_out, tri_out, acc_msb, msb_rise, e.wave, e.tri_v, e.msb, e.rise);
      end
    end
    checks++;
    if ({acc_msb, msb_rise} !== 2'b11) begin
      failures++;
      $display("FAIL saw_rise msb=%b rise=%b required 1 1", acc_msb, msb_rise);
    end
    tick(1'b0);
    void'(sb.pop_front());
    checks++;
    if (wave_out !== 12'h800 || osc_out !== 8'h80 || msb_rise !== 1'b1) begin
      failures++;
      $display("FAIL saw_half wave=%h osc=%h rise=%b required 800 80 1", wave_out, osc_out, msb_rise);
    end
  endtask

  task automatic test_tri_ring();
    control = 8'h10; ring_msb_in = 1'b1;
    tick(1'b0);
    void'(sb.pop_front());
    checks++;
    if (tri_out !== 12'hFFE || wave_out !== 12'hFFE) begin
      failures++;
      $display("FAIL tri_noring tri=%h wave=%h required FFE", tri_out, wave_out);
    end
    control = 8'h14;
    tick(1'b0);
    void'(sb.pop_front());
    checks++;
    if (tri_out !== 12'h000 || wave_out !== 12'h000) begin
      failures++;
      $display("FAIL tri_ring tri=%h wave=%h required 000", tri_out, wave_out);
    end
    ring_msb_in = 1'b0;
    tick(1'b0);
    void'(sb.pop_front());
    checks++;
    if (tri_out !== 12'hFFE) begin
      failures++;
      $display("FAIL tri_ring_low tri=%h required FFE", tri_out);
    end
  endtask

  task automatic test_pulse();
    do_reset();
    pw = 12'h800; freq = 16'h8000; control = 8'h40;
    for (int i = 0; i < 255; i++) begin
      tick(1'b1);
      e = sb.pop_front();
      checks++;
      if (wave_out !== e.wave) begin
        failures++;
        $display("FAIL pulse_step%0d wave=%h required %h", i, wave_out, e.wave);
      end
    end
    tick(1'b0);
    void'(sb.pop_front());
    checks++;
    if (wave_out !== 12'h000) begin
      failures++;
      $display("FAIL pulse_below wave=%h required 000", wave_out);
    end
    tick(1'b1);
    tick(1'b0);
    void'(sb.pop_front()); void'(sb.pop_front());
    checks++;
    if (wave_out !== 12'hFFF) begin
      failures++;
      $display("FAIL pulse_at wave=%h required FFF", wave_out);
    end
    do_reset();
    control = 8'h48;
    tick(1'b0);
    void'(sb.pop_front());
    checks++;
    if (wave_out !== 12'hFFF) begin
      failures++;
      $display("FAIL pulse_test wave=%h required FFF", wave_out);
    end
    control = 8'h40;
    for (int i = 0; i < 4; i++) tick(1'b1);
    sb.delete();
    control = 8'h48;
    tick(1'b0);
    tick(1'b1);
    tick(1'b0);
    for (int i = 0; i < 3; i++) begin
      e = sb.pop_front();
    end
    checks++;
    if (acc_msb !== 1'b0 || wave_out !== 12'hFFF || e.wave !== wave_out) begin
      failures++;
      $display("FAIL pulse_test_zero msb=%b wave=%h required 0 FFF", acc_msb, wave_out);
    end
    control = 8'h60;
    tick(1'b0);
    void'(sb.pop_front());
    checks++;
    if (wave_out !== 12'h000) begin
      failures++;
      $display("FAIL test_acc_zero wave=%h required 000", wave_out);
    end
  endtask

  task automatic build_123456();
    do_reset();
    control = 8'h20; freq = 16'h1200;
    for (int i = 0; i < 256; i++) tick(1'b1);
    freq = 16'h3456;
    tick(1'b1);
    tick(1'b0);
    sb.delete();
  endtask

  task automatic test_sync();
    build_123456();
    checks++;
    if (wave_out !== 12'h123) begin
      failures++;
      $display("FAIL sync_setup wave=%h required 123", wave_out);
    end
    control = 8'h22; sync_in = 1'b1;
    tick(1'b1);
    sync_in = 1'b0;
    tick(1'b0);
    void'(sb.pop_front());
    e = sb.pop_front();
    checks++;
    if ({acc_msb, msb_rise, wave_out} !== 14'h0 || e.wave !== wave_out) begin
      failures++;
      $display("FAIL sync_zero msb=%b rise=%b wave=%h required 0 0 000", acc_msb, msb_rise, wave_out);
    end
    build_123456();
    control = 8'h20; sync_in = 1'b1;
    tick(1'b1);
    sync_in = 1'b0;
    tick(1'b0);
    void'(sb.pop_front());
    e = sb.pop_front();
    checks++;
    if (wave_out !== 12'h126 || e.wave !== wave_out) begin
      failures++;
      $display("FAIL sync_off wave=%h required 126", wave_out);
    end
  endtask

  task automatic test_noise();
    do_reset();
    control = 8'h80; freq = 16'h8000;
    tick(1'b0);
    e = sb.pop_front();
    checks++;
    if (wave_out !== noise_of(SEED) || wave_out !== e.wave) begin
      failures++;
      $display("FAIL noise_seed wave=%h required %h", wave_out, noise_of(SEED));
    end
    for (int i = 0; i < 16; i++) tick(1'b1);
    tick(1'b0);
    for (int i = 0; i < 17; i++) e = sb.pop_front();
    checks++;
    if (wave_out !== noise_of(23'h7FFFF0) || wave_out !== e.wave) begin
      failures++;
      $display("FAIL noise_first wave=%h required %h", wave_out, noise_of(23'h7FFFF0));
    end
    for (int i = 0; i < 400; i++) begin
      tick(1'b1);
      e = sb.pop_front();
      checks++;
      if (wave_out !== e.wave) begin
        failures++;
        $display("FAIL noise_step%0d wave=%h required %h", i, wave_out, e.wave);
      end
    end
    control = 8'h88;
    tick(1'b1);
    control = 8'h80;
    tick(1'b0);
    void'(sb.pop_front());
    e = sb.pop_front();
    checks++;
    if (wave_out !== noise_of(SEED) || wave_out !== e.wave) begin
      failures++;
      $display("FAIL noise_reload wave=%h required %h", wave_out, noise_of(SEED));
    end
  endtask

  task automatic test_combo_reset();
    do_reset();
    control = 8'h60; pw = 12'h100; freq = 16'hA5C0;
    for (int i = 0; i < 256; i++) tick(1'b1);
    tick(1'b0);
    while (sb.size() > 0) e = sb.pop_front();
    checks++;
    if (wave_out !== 12'hA5C || e.wave !== wave_out) begin
      failures++;
      $display("FAIL saw_pulse wave=%h required A5C", wave_out);
    end
    control = 8'h70;
    reset = 1'b1;
    tick(1'b1);
    reset = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({wave_out, tri_out, osc_out, acc_msb, msb_rise} !== 34'h0) begin
      failures++;
      $display("FAIL midrun_reset wave=%h tri=%h osc=%h msb=%b required 0", wave_out, tri_out, osc_out, acc_msb);
    end
    control = 8'h20;
    tick(1'b1);
    tick(1'b0);
    void'(sb.pop_front());
    e = sb.pop_front();
    checks++;
    if (wave_out !== 12'h00A || e.wave !== wave_out) begin
      failures++;
      $display("FAIL post_reset_add wave=%h required 00A", wave_out);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      freq        = 16'($urandom);
      pw          = 12'($urandom);
      control     = {4'($urandom), ($urandom_range(0, 15) == 0), 3'($urandom)};
      sync_in     = 1'($urandom);
      ring_msb_in = 1'($urandom);
      reset       = ($urandom_range(0, 99) == 0);
      tick(1'($urandom));
      e = sb.pop_front();
      checks++;
      if ({wave_out, tri_out, acc_msb, msb_rise} !== {e.wave, e.tri_v, e.msb, e.rise}) begin
        failures++;
        $display("FAIL rand_step%0d wave=%h tri=%h msb=%b rise=%b required %h %h %b %b", i,
                 wave_out, tri_out, acc_msb, msb_rise, e.wave, e.tri_v, e.msb, e.rise);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_saw();
    test_tri_ring();
    test_pulse();
    test_sync();
    test_noise();
    test_combo_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
